// File: rtl/stepdir_pkg.sv
// Purpose : shared types and helpers for the step/direction conditioner.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package stepdir_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_e;

    // One buffered step request waiting for the pulse engine.
    typedef struct packed {
        logic vld;
        logic dir;
    } slot_t;

    // Largest of two cycle counts, never below one: a zero-length timed
    // state would otherwise underflow the down-counter load value.
    function automatic int max_cycles(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : m;
    endfunction

    // Position increment for one emitted pulse: forward +1, reverse -1.
    function automatic logic signed [31:0] step_delta(input logic fwd);
        return fwd ? 32'sd1 : -32'sd1;
    endfunction

endpackage

// File: rtl/stepdir_timer.sv
// Purpose : shared down-counter timing every timed state of the conditioner.
// Latency : load takes effect next cycle; done is high while the count is zero.
// Backpressure: none; a load always wins over counting.
// Ports   : clk, rst_n, load (restart), load_val (cycles-1), done (count == 0).
module stepdir_timer
    import stepdir_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/stepdir_conditioner.sv
// Purpose : turns raw step edges into driver-legal STP/DIR pulses with position count.
// Latency : STP rises 1 cycle after capture; DIR_SETUP_CYCLES more on a reversal.
// Backpressure: one pending step buffered; further requests dropped and flagged by overrun.
// Ports   : clk, rst_n, jointEnable, stepIn, dirIn -> STP, DIR, jointFeedback (signed
//           emitted pulse count), overrun (sticky dropped-request flag).
module stepdir_conditioner
    import stepdir_pkg::*;
#(
    parameter int DIR_SETUP_CYCLES = 50,
    parameter int STEP_HIGH_CYCLES = 100,
    parameter int STEP_LOW_CYCLES  = 100,
    parameter int DIR_HOLD_CYCLES  = 50,
    parameter int CNT_W            = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               jointEnable,
    input  logic               stepIn,
    input  logic               dirIn,
    output logic               STP,
    output logic               DIR,
    output logic signed [31:0] jointFeedback,
    output logic               overrun
);

    // Counter load values are length-1: the timer sits on each value for one
    // cycle and the state exits on the cycle it reads zero.
    localparam logic [CNT_W-1:0] SETUP_LD =
        CNT_W'(max_cycles(DIR_SETUP_CYCLES, DIR_SETUP_CYCLES) - 1);
    localparam logic [CNT_W-1:0] HIGH_LD =
        CNT_W'(max_cycles(STEP_HIGH_CYCLES, STEP_HIGH_CYCLES) - 1);
    // The low phase doubles as the DIR hold window, so it covers both.
    localparam logic [CNT_W-1:0] LOW_LD =
        CNT_W'(max_cycles(STEP_LOW_CYCLES, DIR_HOLD_CYCLES) - 1);

    logic               step_in_q, step_in_d;
    slot_t              slot_q, slot_d;
    logic               overrun_q, overrun_d;
    state_e             state_q, state_d;
    logic               stp_q, stp_d;
    logic               dir_q, dir_d;
    logic signed [31:0] fb_q, fb_d;

    logic               step_req;
    logic               consume;
    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_val;
    logic               tmr_done;

    assign step_req = stepIn & ~step_in_q;
    // A disabled joint never starts a new pulse; the slot is flushed instead.
    assign consume  = (state_q == IDLE) & slot_q.vld & jointEnable;

    // Pending slot and overrun bookkeeping.
    always_comb begin
        step_in_d = stepIn;
        slot_d    = slot_q;
        overrun_d = overrun_q;
        if (!jointEnable) begin
            slot_d    = '0;
            overrun_d = 1'b0;
        end else begin
            if (consume) begin
                slot_d.vld = 1'b0;
            end
            if (step_req) begin
                // Refilling the slot in the cycle it drains is not an overrun.
                if (slot_q.vld && !consume) begin
                    overrun_d = 1'b1;
                end else begin
                    slot_d = '{vld: 1'b1, dir: dirIn};
                end
            end
        end
    end

    // Pulse engine.
    always_comb begin
        state_d  = state_q;
        stp_d    = stp_q;
        dir_d    = dir_q;
        fb_d     = fb_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            IDLE: begin
                if (consume) begin
                    if (slot_q.dir != dir_q) begin
                        // DIR only ever moves here, so setup and hold are
                        // guaranteed by the SETUP and LOW phases around it.
                        dir_d    = slot_q.dir;
                        state_d  = SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = SETUP_LD;
                    end else begin
                        stp_d    = 1'b1;
                        fb_d     = fb_q + step_delta(slot_q.dir);
                        state_d  = HIGH;
                        tmr_load = 1'b1;
                        tmr_val  = HIGH_LD;
                    end
                end
            end
            SETUP: begin
                if (tmr_done) begin
                    stp_d    = 1'b1;
                    fb_d     = fb_q + step_delta(dir_q);
                    state_d  = HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = HIGH_LD;
                end
            end
            HIGH: begin
                if (tmr_done) begin
                    stp_d    = 1'b0;
                    state_d  = LOW;
                    tmr_load = 1'b1;
                    tmr_val  = LOW_LD;
                end
            end
            LOW: begin
                if (tmr_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_in_q <= 1'b0;
            slot_q    <= '0;
            overrun_q <= 1'b0;
            state_q   <= IDLE;
            stp_q     <= 1'b0;
            dir_q     <= 1'b0;
            fb_q      <= '0;
        end else begin
            step_in_q <= step_in_d;
            slot_q    <= slot_d;
            overrun_q <= overrun_d;
            state_q   <= state_d;
            stp_q     <= stp_d;
            dir_q     <= dir_d;
            fb_q      <= fb_d;
        end
    end

    stepdir_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .load_val(tmr_val),
        .done    (tmr_done)
    );

    assign STP           = stp_q;
    assign DIR           = dir_q;
    assign jointFeedback = fb_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_stepdir_conditioner.sv
// Purpose : directed self-checking bench for stepdir_conditioner.
// Latency : n/a.
// Backpressure: n/a.
module tb_stepdir_conditioner;

    logic               clk;
    logic               rst_n;
    logic               jointEnable;
    logic               stepIn;
    logic               dirIn;
    logic               STP;
    logic               DIR;
    logic signed [31:0] jointFeedback;
    logic               overrun;

    int n_checks = 0;
    int n_fail   = 0;

    stepdir_conditioner #(
        .DIR_SETUP_CYCLES(4),
        .STEP_HIGH_CYCLES(5),
        .STEP_LOW_CYCLES (6),
        .DIR_HOLD_CYCLES (3),
        .CNT_W           (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .jointEnable  (jointEnable),
        .stepIn       (stepIn),
        .dirIn        (dirIn),
        .STP          (STP),
        .DIR          (DIR),
        .jointFeedback(jointFeedback),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, leaving time 1 unit after the last edge.
    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle stepIn pulse; returns 1 unit after the capturing edge.
    task automatic step_req(input logic d);
        stepIn = 1'b1;
        dirIn  = d;
        adv(1);
        stepIn = 1'b0;
    endtask

    // Count STP-high samples over n cycles.
    task automatic count_high(input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            adv(1);
            if (STP) highs++;
        end
    endtask

    int highs;

    initial begin
        rst_n       = 1'b0;
        jointEnable = 1'b1;
        stepIn      = 1'b0;
        dirIn       = 1'b0;
        #12;
        check_eq("rst_stp", 32'(STP), 32'd0);
        check_eq("rst_dir", 32'(DIR), 32'd0);
        check_eq("rst_fb",  32'(jointFeedback), 32'd0);
        check_eq("rst_ovr", 32'(overrun), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        adv(2);

        // Forward step from reset: DIR flips first, then setup delay.
        step_req(1'b1);                       // k
        check_eq("t2_dir_k", 32'(DIR), 32'd0);
        adv(1);                               // k+1
        check_eq("t2_dir_k1", 32'(DIR), 32'd1);
        check_eq("t2_stp_k1", 32'(STP), 32'd0);
        adv(3);                               // k+4
        check_eq("t2_stp_k4", 32'(STP), 32'd0);
        adv(1);                               // k+5
        check_eq("t2_stp_k5", 32'(STP), 32'd1);
        check_eq("t2_fb", 32'(jointFeedback), 32'd1);
        adv(4);                               // k+9
        check_eq("t2_stp_k9", 32'(STP), 32'd1);
        adv(1);                               // k+10
        check_eq("t2_stp_k10", 32'(STP), 32'd0);
        adv(10);

        // Same direction from idle: no setup delay.
        step_req(1'b1);                       // k
        check_eq("t3_stp_k", 32'(STP), 32'd0);
        adv(1);                               // k+1
        check_eq("t3_stp_k1", 32'(STP), 32'd1);
        check_eq("t3_fb", 32'(jointFeedback), 32'd2);
        adv(4);                               // k+5
        check_eq("t3_stp_k5", 32'(STP), 32'd1);
        check_eq("t3_dir", 32'(DIR), 32'd1);
        adv(1);                               // k+6
        check_eq("t3_stp_k6", 32'(STP), 32'd0);
        adv(8);

        // Three requests two cycles apart: third overruns.
        step_req(1'b1);                       // k
        adv(1);                               // k+1
        check_eq("t4_stp_k1", 32'(STP), 32'd1);
        step_req(1'b1);                       // k+2
        adv(1);                               // k+3
        check_eq("t4_ovr_k3", 32'(overrun), 32'd0);
        step_req(1'b1);                       // k+4
        check_eq("t4_ovr_k4", 32'(overrun), 32'd1);
        adv(1);                               // k+5
        check_eq("t4_stp_k5", 32'(STP), 32'd1);
        adv(1);                               // k+6
        check_eq("t4_stp_k6", 32'(STP), 32'd0);
        adv(6);                               // k+12
        check_eq("t4_stp_k12", 32'(STP), 32'd0);
        adv(1);                               // k+13
        check_eq("t4_stp_k13", 32'(STP), 32'd1);
        check_eq("t4_fb", 32'(jointFeedback), 32'd4);
        adv(4);                               // k+17
        check_eq("t4_stp_k17", 32'(STP), 32'd1);
        count_high(13, highs);                // k+18..k+30
        check_eq("t4_no_third", 32'(highs), 32'd0);
        check_eq("t4_fb_end", 32'(jointFeedback), 32'd4);

        // Reversal requested while a forward pulse is high.
        step_req(1'b1);                       // k
        adv(1);                               // k+1
        check_eq("t5_stp_k1", 32'(STP), 32'd1);
        check_eq("t5_fb_fwd", 32'(jointFeedback), 32'd5);
        step_req(1'b0);                       // k+2
        check_eq("t5_dir_k2", 32'(DIR), 32'd1);
        adv(4);                               // k+6
        check_eq("t5_stp_k6", 32'(STP), 32'd0);
        adv(6);                               // k+12
        check_eq("t5_dir_hold", 32'(DIR), 32'd1);
        adv(1);                               // k+13
        check_eq("t5_dir_k13", 32'(DIR), 32'd0);
        adv(3);                               // k+16
        check_eq("t5_stp_k16", 32'(STP), 32'd0);
        adv(1);                               // k+17
        check_eq("t5_stp_k17", 32'(STP), 32'd1);
        check_eq("t5_fb_rev", 32'(jointFeedback), 32'd4);
        adv(12);
        check_eq("t5_ovr_sticky", 32'(overrun), 32'd1);

        // Disable in HIGH cycle 2 with a request pending.
        step_req(1'b0);                       // k
        adv(1);                               // k+1
        check_eq("t6_stp_k1", 32'(STP), 32'd1);
        step_req(1'b0);                       // k+2, pending
        jointEnable = 1'b0;
        adv(1);                               // k+3
        check_eq("t6_ovr_clr", 32'(overrun), 32'd0);
        check_eq("t6_stp_k3", 32'(STP), 32'd1);
        adv(2);                               // k+5
        check_eq("t6_stp_k5", 32'(STP), 32'd1);
        adv(1);                               // k+6
        check_eq("t6_stp_k6", 32'(STP), 32'd0);
        step_req(1'b1);                       // ignored while disabled
        count_high(20, highs);
        check_eq("t6_no_stp", 32'(highs), 32'd0);
        check_eq("t6_fb", 32'(jointFeedback), 32'd3);
        check_eq("t6_dir", 32'(DIR), 32'd0);

        // Reset mid-HIGH with overrun set.
        jointEnable = 1'b1;
        adv(2);
        step_req(1'b1);                       // k, reversal
        adv(1);                               // k+1
        step_req(1'b1);                       // k+2, pending
        adv(1);                               // k+3
        step_req(1'b1);                       // k+4, overrun
        adv(2);                               // k+6
        check_eq("t1_stp_pre", 32'(STP), 32'd1);
        check_eq("t1_ovr_pre", 32'(overrun), 32'd1);
        check_eq("t1_fb_pre", 32'(jointFeedback), 32'd4);
        rst_n = 1'b0;
        #2;
        check_eq("t1_stp", 32'(STP), 32'd0);
        check_eq("t1_dir", 32'(DIR), 32'd0);
        check_eq("t1_fb",  32'(jointFeedback), 32'd0);
        check_eq("t1_ovr", 32'(overrun), 32'd0);
        adv(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stepdir_conditioner.md
Name: stepdir_conditioner

Overview:
Sits directly downstream of the joint step generator, between its raw STP/DIR pair and the external stepper driver pins. It converts each rising edge of the raw step signal into a driver-legal pulse. Driver-legal means guaranteed DIR setup before STP rises, DIR hold after STP falls, and minimum STP high and low widths. It buffers one pending step, flags overruns, and keeps a position count of pulses actually emitted to the driver.

Parameters:
DIR_SETUP_CYCLES, 50, clk cycles DIR must be stable before STP rises (1 us at 50 MHz)
STEP_HIGH_CYCLES, 100, STP high width in clk cycles
STEP_LOW_CYCLES, 100, minimum STP low width in clk cycles
DIR_HOLD_CYCLES, 50, clk cycles DIR must be held after STP falls
CNT_W, 16, width of the internal timing counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
jointEnable  input  1  joint enable; low blocks new steps
stepIn  input  1  raw step from the step generator; each rising edge is one step request
dirIn  input  1  raw direction from the step generator; 1 = forward
STP  output  1  conditioned step to the driver
DIR  output  1  conditioned direction to the driver
jointFeedback  output  32  signed count of emitted pulses
overrun  output  1  sticky flag: a step request was dropped

Behaviour:
- Reset (async, rst_n=0): STP=0, DIR=0, jointFeedback=0, overrun=0, pending slot empty, stepInQ=0, state IDLE. All outputs are registered.
- Edge detect: stepReq = stepIn & ~stepInQ. stepInQ is stepIn registered. There is no synchroniser; stepIn is in the clk domain.
- Pending slot {valid, dir}. On stepReq with jointEnable=1, the slot loads {1, dirIn}.
- If the slot is valid and is not consumed in the same cycle as a stepReq, the request is dropped and overrun<=1.
- Consume and refill in the same cycle is legal and does not set overrun.
- States:
  - IDLE: with slot valid, the slot is consumed.
    - If slot.dir != DIR: DIR<=slot.dir, go to SETUP.
    - Otherwise: STP<=1, jointFeedback +/-1 per slot.dir, go to HIGH.
  - SETUP: lasts DIR_SETUP_CYCLES cycles. On exit, STP<=1, jointFeedback +/-1, go to HIGH.
  - HIGH: STP=1 for STEP_HIGH_CYCLES cycles. On exit, STP<=0, go to LOW.
  - LOW: lasts max(STEP_LOW_CYCLES, DIR_HOLD_CYCLES) cycles, then IDLE. DIR never changes outside IDLE.
- Timing:
  - Request captured at posedge k, same direction: STP rises at posedge k+1.
  - Reversal: DIR changes at k+1, STP rises at k+1+DIR_SETUP_CYCLES.
  - Minimum step period is STEP_HIGH + max(LOW, HOLD) + 1 cycles, plus DIR_SETUP on a reversal.
- Parameter value 0 is treated as 1. The counter loads value-1 and counts down to 0.
- jointFeedback updates in the same cycle STP rises. It uses 32-bit two's-complement wrap, no saturation.
- jointEnable=0:
  - New requests are ignored.
  - The pending slot is cleared and overrun is cleared.
  - A pulse already in SETUP/HIGH/LOW completes normally, with no runt pulse.
  - DIR holds its value.
- overrun stays set until jointEnable=0 or reset.
- Reset mid-pulse: outputs drop to reset values immediately. This is accepted.

Decomposition:
- Package stepdir_pkg:
  - State enum (IDLE, SETUP, HIGH, LOW).
  - CNT_W default.
  - Function max_cycles(a,b) returning max(a,b,1).
- One sub-module, stepdir_timer: a CNT_W down-counter with load, load value, and a done output. It is instantiated once and shared by all timed states.

Test Plan:
All scenarios use DIR_SETUP=4, STEP_HIGH=5, STEP_LOW=6, DIR_HOLD=3.
1. Reset: assert rst_n=0 mid-HIGH -> STP=0, DIR=0, jointFeedback=0, overrun=0 immediately, asynchronously.
2. Forward step from reset (dirIn=1, one stepIn rise captured at k) -> DIR=1 at k+1, STP high k+5..k+9, low from k+10, jointFeedback=1.
3. Second forward request after return to IDLE -> STP rises 1 cycle after capture with no setup delay; jointFeedback=2.
4. Three forward requests 2 cycles apart -> exactly two pulses, each 5 high, gap >=7 cycles edge-to-edge low-to-high; overrun=1; jointFeedback +2.
5. Reversal (dirIn=0 request while a forward pulse is in HIGH) -> DIR falls no earlier than 6 cycles after STP falls; STP rises exactly 4 cycles after DIR falls; jointFeedback decrements by 1.
6. jointEnable dropped in HIGH cycle 2 with a request pending -> STP stays high the full 5 cycles; pending discarded; overrun cleared; no further STP while disabled.
